async_fifo_rd_ctrl: RTL and testbench

Read-side controller of the PCS RX clock-domain-crossing FIFO, running entirely in the rclk domain. Consumes the Gray write pointer already double-flopped into rclk, keeps the binary and Gray read pointers, and generates empty, almost-empty and fill-level status. Drives the synchronous-read dual-port RAM and presents first-word-fall-through data downstream on a valid/ready handshake at one word per rclk.

---
 rtl/async_fifo_rd_ctrl_pkg.sv | 14 +
 rtl/async_fifo_rd_ctrl_gray2bin.sv | 17 +
 rtl/async_fifo_rd_ctrl.sv | 103 ++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_rd_ctrl_pkg.sv
// Shared definitions for the PCS RX CDC FIFO read side: default geometry,
// almost-empty threshold and the binary-to-Gray helper.
package async_fifo_rd_ctrl_pkg;

  localparam int unsigned ADDRSIZE_DEF      = 5;
  localparam int unsigned DSIZE_DEF         = 66;
  localparam int unsigned AEMPTY_THRESH_DEF = 4;

  // Wide enough for any pointer width used here; callers truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray2bin.sv
// Gray-to-binary decode as a combinational XOR prefix.
module gray2bin #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the PCS RX clock-domain-crossing FIFO.
// Keeps the read pointers, derives empty / almost-empty / level status from
// the synchronized Gray write pointer, drives the synchronous-read RAM and
// presents first-word-fall-through data through a two-entry output buffer.
module async_fifo_rd_ctrl
  import async_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = ADDRSIZE_DEF,
  parameter int unsigned DSIZE         = DSIZE_DEF,
  parameter int unsigned AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rden,
  input  logic [DSIZE-1:0]    rdata_mem,
  output logic [DSIZE-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0]    rbin;
  logic [PW-1:0]    rbinnext;
  logic [PW-1:0]    rgraynext;
  logic [PW-1:0]    wbin;
  logic [PW-1:0]    level_next;
  logic [1:0]       bcnt;
  logic [1:0]       bcnt_after;
  logic [1:0]       bcnt_next;
  logic             inflight;
  logic             pop;
  logic [DSIZE-1:0] skid;

  gray2bin #(.W(PW)) u_wptr_dec (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign raddr = rbin[ADDRSIZE-1:0];

  // Read issue, next pointers and buffer occupancy bookkeeping.
  always_comb begin
    pop        = dout_valid & dout_ready;
    // Issue only if the buffer, counting the word still in flight, keeps a free slot.
    rden       = !rempty && (({1'b0, bcnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
    rbinnext   = rbin + PW'(rden);
    rgraynext  = PW'(bin2gray(32'(rbinnext)));
    level_next = wbin - rbinnext;
    bcnt_after = bcnt - {1'b0, pop};
    bcnt_next  = bcnt_after + {1'b0, inflight};
  end

  // Pointer and status registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rlevel  <= '0;
    end else begin
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      rempty  <= (rgraynext == rq2_wptr);
      rlevel  <= level_next;
      raempty <= (level_next <= PW'(AEMPTY_THRESH));
    end
  end

  // Two-entry output buffer: head drives dout, skid absorbs the word that
  // lands while the head is still waiting for the downstream.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout       <= '0;
      skid       <= '0;
      bcnt       <= '0;
      inflight   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      inflight <= rden;
      bcnt     <= bcnt_next;
      if (pop && (bcnt == 2'd2)) begin
        dout <= skid;
      end
      if (inflight) begin
        if (bcnt_after == 2'd0) begin
          dout <= rdata_mem;
        end else begin
          skid <= rdata_mem;
        end
      end
      dout_valid <= (bcnt_next != 2'd0);
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scoreboard bench for async_fifo_rd_ctrl with a behavioural RAM/write side.
module tb_async_fifo_rd_ctrl;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [5:0]  rq2_wptr = '0;
  logic [5:0]  rptr;
  logic [4:0]  raddr;
  logic        rden;
  logic [65:0] rdata_mem = '0;
  logic [65:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        rempty;
  logic        raempty;
  logic [5:0]  rlevel;

  async_fifo_rd_ctrl #(.ADDRSIZE(5), .DSIZE(66), .AEMPTY_THRESH(4)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rq2_wptr   (rq2_wptr),
    .rptr       (rptr),
    .raddr      (raddr),
    .rden       (rden),
    .rdata_mem  (rdata_mem),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel)
  );

  always #5 rclk = ~rclk;

  logic [65:0] mem [32];
  always @(posedge rclk) if (rden) rdata_mem <= mem[raddr];

  int checks = 0;
  int errors = 0;
  int written = 0;
  int issued = 0;
  int popped = 0;
  int gaps = 0;
  bit track = 0;
  bit seen = 0;
  bit prev_hold = 0;
  logic [65:0] prev_dout;
  logic [65:0] exp_q [$];

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray6(input int b);
    int x;
    x = b % 64;
    return x ^ (x >> 1);
  endfunction

  task automatic push_word(output logic [65:0] d);
    d = {2'($urandom), 32'($urandom), 32'($urandom)};
    mem[written % 32] = d;
    exp_q.push_back(d);
    written++;
    rq2_wptr = 6'(gray6(written));
  endtask

  function automatic bit has_space();
    return (written - issued) < 32;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic sample(input int n);
    repeat (n) @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic drain(input string nm);
    dout_ready = 1'b1;
    for (int i = 0; i < 300 && popped < written; i++) tick();
    checki(nm, popped, written);
  endtask

  // Monitor: in-order address/pointer model, output ordering and hold stability.
  always @(negedge rclk) begin
    if (rrst_n) begin
      checki("rptr_gray", int'(rptr), gray6(issued));
      if (rden) begin
        checki("raddr_order", int'(raddr), issued % 32);
        checki("rden_nonempty", (issued < written) ? 1 : 0, 1);
        issued++;
      end
      if (prev_hold) begin
        checki("hold_valid", int'(dout_valid), 1);
        check("hold_dout", dout, prev_dout);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checki("pop_unexpected", 1, 0);
        end else begin
          check("dout_data", dout, exp_q.pop_front());
        end
        popped++;
      end
      checki("buffered_le2", ((issued - popped) <= 2) ? 1 : 0, 1);
      if (track) begin
        if (dout_valid) seen = 1;
        else if (seen) gaps++;
      end
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout;
    end else begin
      prev_hold = 0;
    end
  end

  task automatic check_reset_values();
    checki("rst_rempty", int'(rempty), 1);
    checki("rst_raempty", int'(raempty), 1);
    checki("rst_rlevel", int'(rlevel), 0);
    checki("rst_rptr", int'(rptr), 0);
    checki("rst_rden", int'(rden), 0);
    checki("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", dout, '0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    written = 0;
    issued = 0;
    popped = 0;
    rq2_wptr = '0;
  endtask

  initial begin
    logic [65:0] d;
    logic [65:0] word;

    // Power-on reset.
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    check_reset_values();
    tick();
    rrst_n = 1'b1;
    sample(1);
    checki("post_rst_rden", int'(rden), 0);
    tick();

    // Single word: pointer moves just after edge E.
    dout_ready = 1'b1;
    push_word(word);
    sample(1);
    checki("sw_rden_e1", int'(rden), 1);
    checki("sw_raddr_e1", int'(raddr), 0);
    checki("sw_rempty_e1", int'(rempty), 0);
    sample(1);
    checki("sw_rden_e2", int'(rden), 0);
    checki("sw_rempty_e2", int'(rempty), 1);
    checki("sw_valid_e2", int'(dout_valid), 0);
    sample(1);
    checki("sw_valid_e3", int'(dout_valid), 1);
    check("sw_dout_e3", dout, word);
    tick();

    // Streaming 100 words with a 5-cycle backpressure window.
    track = 1;
    seen = 0;
    gaps = 0;
    repeat (4) push_word(d);
    for (int i = 0; i < 400 && written < 101; i++) begin
      if (written == 50 && dout_ready) begin
        dout_ready = 1'b0;
        repeat (3) begin
          if (has_space()) push_word(d);
          tick();
        end
        @(negedge rclk);
        checki("bp_rden_stopped", int'(rden), 0);
        checki("bp_valid", int'(dout_valid), 1);
        checki("bp_buffered", issued - popped, 2);
        repeat (2) tick();
        dout_ready = 1'b1;
      end
      if (has_space()) push_word(d);
      tick();
    end
    track = 0;
    checki("stream_gaps", gaps, 0);
    drain("stream_drain");

    // Randomized backpressure and write rate.
    for (int i = 0; i < 1500; i++) begin
      dout_ready = 1'($urandom);
      if (has_space() && ($urandom_range(0, 2) != 0)) push_word(d);
      tick();
    end
    drain("random_drain");
    tick();
    @(negedge rclk);
    checki("random_rempty", int'(rempty), 1);
    checki("random_rlevel", int'(rlevel), 0);

    // Reset in the middle of a stream.
    tick();
    repeat (10) push_word(d);
    repeat (3) tick();
    #2;
    rrst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    tick();
    rrst_n = 1'b1;
    sample(1);
    checki("mid_rst_rden", int'(rden), 0);
    checki("mid_rst_rempty", int'(rempty), 1);
    tick();

    // Full FIFO then drain through the almost-empty threshold.
    dout_ready = 1'b1;
    repeat (32) push_word(d);
    for (int n = 1; n <= 33; n++) begin
      sample(1);
      checki("full_rlevel", int'(rlevel), 33 - n);
      checki("full_raempty", int'(raempty), ((33 - n) <= 4) ? 1 : 0);
      checki("full_rempty", int'(rempty), (n == 33) ? 1 : 0);
    end
    drain("full_drain");
    checki("full_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
